led_pattern_seq: RTL
====================

// Module: led_pattern_seq
// PURPOSE
//  Downstream consumer of the blink counter stage. Takes its period strobe (tick, driven by flg) and its
//  free-running level (base_led, driven by led). Plays a loaded on/off bit pattern on led_out, one bit per tick.
//  Repeats the pattern a programmed number of times, inserts a dark gap, then returns to base_led passthrough.
//  Patterns are loaded through a valid/ready handshake from the control side.
// PARAMETERS
//  PLEN      8  pattern length in bits (>=2); bit 0 plays first
//  RBITS     4  width of repeat count; total plays = pat_reps+1
//  GAP_TICKS 2  ticks of forced-dark gap after last play (0 = no gap)
// PORTS
//  clk        in   1      clock
//  rst        in   1      reset, asynchronous, active-high
//  tick       in   1      one-cycle period strobe from blink stage (flg)
//  base_led   in   1      blink stage led level, passed through when idle
//  pat_valid  in   1      pattern offer
//  pat_data   in   PLEN   pattern bits
//  pat_reps   in   RBITS  extra repetitions
//  pat_ready  out  1      = (state==IDLE); combinational from state only
//  abort      in   1      synchronous cancel of playback
//  led_out    out  1      registered LED drive
//  busy       out  1      = (state!=IDLE)
//  done       out  1      registered one-cycle pulse on normal completion
// BEHAVIOUR
//  Reset: state=IDLE, led_out=0, done=0, shreg/bit_idx/rep_cnt/gap_cnt=0. Hence pat_ready=1 and busy=0 after reset.
//  Reset asserted mid-playback clears everything immediately; no done is issued.
//  All outputs except pat_ready/busy are registered. A value computed in cycle n appears in cycle n+1.
//  States:
//   IDLE: led_out<=base_led (1-cycle delay).
//     On pat_valid&&pat_ready: capture pat_data->shreg, pat_reps->reps; bit_idx<=0, rep_cnt<=0; go RUN.
//     A tick in the accept cycle is ignored.
//   RUN: led_out<=shreg[bit_idx] every cycle. Entry cycle shows bit 0 for a partial interval up to the first tick.
//     On tick with bit_idx<PLEN-1: bit_idx++.
//     On tick with bit_idx==PLEN-1: bit_idx<=0.
//       If rep_cnt<reps: rep_cnt++ and stay in RUN.
//       Else: go GAP with gap_cnt<=0. If GAP_TICKS==0, go IDLE instead and pulse done.
//   GAP: led_out<=0. On tick: gap_cnt++. When gap_cnt reaches GAP_TICKS (i.e. on that tick):
//     go IDLE and set done<=1 for one cycle.
//  abort (any state, level-sampled) beats tick and pat_valid in the same cycle:
//   next state IDLE, led_out<=0 for that cycle (passthrough resumes the cycle after), done stays 0.
//   abort in IDLE also blocks acceptance: no capture, even though pat_ready=1.
//  pat_valid outside IDLE is ignored (ready=0). Offering side must hold data until accepted.
//  Counters: bit_idx width clog2(PLEN); gap_cnt width clog2(GAP_TICKS+1). No wrap other than bit_idx PLEN-1->0.
//  pat_reps=0: pattern plays exactly once. pat_reps=2^RBITS-1: plays 2^RBITS times with no overflow.
//  Ticks on consecutive cycles are legal; each advances exactly one step.
//  Total ticks per job = PLEN*(reps+1)+GAP_TICKS.
// TESTING
//  1. Reset then idle: base_led toggles -> led_out follows one cycle later; pat_ready=1, busy=0, done=0.
//  2. Load pat_data=8'b1010_0011, reps=0, 10 ticks ->
//     led_out seq per tick interval 1,1,0,0,0,1,0,1, then 0,0; done pulses exactly once on 10th tick+1 cycle.
//  3. reps=2, pat=8'hFF, GAP_TICKS=2 -> led_out high for 24 tick intervals, dark for 2, done after 26th tick.
//  4. abort asserted after 3 ticks of playback -> next cycle led_out=0, state IDLE, no done;
//     a new pattern is accepted on the following cycle.
//  5. Simultaneous pat_valid+tick in IDLE -> accepted, bit_idx stays 0 until the next tick.
//     Simultaneous abort+pat_valid -> not accepted.
//  6. Async rst pulse mid-RUN (between clock edges) -> led_out=0, busy=0 immediately;
//     after release, passthrough of base_led resumes.

Source files
------------

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: plays a loaded bit pattern on the LED one bit per tick, with repeats and a dark gap, else passes base_led through.
module led_pattern_seq #(
    parameter int PLEN      = 8,
    parameter int RBITS     = 4,
    parameter int GAP_TICKS = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             base_led,
    input  logic             pat_valid,
    input  logic [PLEN-1:0]  pat_data,
    input  logic [RBITS-1:0] pat_reps,
    output logic             pat_ready,
    input  logic             abort,
    output logic             led_out,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(PLEN);
    localparam int GW = GAP_TICKS > 0 ? $clog2(GAP_TICKS + 1) : 1;
    typedef enum logic [1:0] {IDLE, RUN, GAP} state_t;
    state_t            state_q, state_d;
    logic [PLEN-1:0]   shreg_q, shreg_d;
    logic [RBITS-1:0]  reps_q, reps_d, rep_cnt_q, rep_cnt_d;
    logic [BW-1:0]     bit_idx_q, bit_idx_d;
    logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
    logic              led_q, led_d, done_q, done_d;
    assign pat_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign led_out   = led_q;
    assign done      = done_q;
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        reps_d    = reps_q;
        rep_cnt_d = rep_cnt_q;
        bit_idx_d = bit_idx_q;
        gap_cnt_d = gap_cnt_q;
        led_d     = 1'b0;
        done_d    = 1'b0;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    led_d = base_led;
                    if (pat_valid) begin
                        shreg_d   = pat_data;
                        reps_d    = pat_reps;
                        bit_idx_d = '0;
                        rep_cnt_d = '0;
                        state_d   = RUN;
                    end
                end
                RUN: begin
                    led_d = shreg_q[bit_idx_q];
                    if (tick) begin
                        if (bit_idx_q == BW'(PLEN - 1)) begin
                            bit_idx_d = '0;
                            if (rep_cnt_q < reps_q) begin
                                rep_cnt_d = rep_cnt_q + 1'b1;
                            end else if (GAP_TICKS == 0) begin
                                state_d = IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d   = GAP;
                                gap_cnt_d = '0;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        gap_cnt_d = gap_cnt_q + 1'b1;
                        if (gap_cnt_q == GW'(GAP_TICKS - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            reps_q    <= '0;
            rep_cnt_q <= '0;
            bit_idx_q <= '0;
            gap_cnt_q <= '0;
            led_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            reps_q    <= reps_d;
            rep_cnt_q <= rep_cnt_d;
            bit_idx_q <= bit_idx_d;
            gap_cnt_q <= gap_cnt_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end
endmodule
